// File: rtl/cache_pkg.sv
// Shared cache definitions: command encodings, field widths, dispatcher state and small helpers.
// Used by the cache command dispatcher (optional DISPATCH_STATS_EN counters use sat_inc).
package cache_pkg;

    localparam int ADDR_W  = 60;
    localparam int CMD_W   = 3;
    localparam int ENTRY_W = CMD_W + ADDR_W;

    typedef enum logic [CMD_W-1:0] {
        CMD_READ          = 3'd0,
        CMD_WRITE         = 3'd1,
        CMD_INVALIDATE    = 3'd2,
        CMD_CLEAR         = 3'd3,
        CMD_L2DATAREQUEST = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } disp_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    function automatic logic is_legal_cmd(input logic [CMD_W-1:0] c);
        return c <= CMD_L2DATAREQUEST;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cache_cmd_dispatcher_if.sv
// Trace-side handshake plus cache-side command bus of the dispatcher.
// slave = dispatcher view; master = trace source and cache seen from outside.
interface cache_cmd_dispatcher_if;
    import cache_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CMD_W-1:0]  in_cmd;
    logic [ADDR_W-1:0] in_addr;
    logic              write;
    logic [CMD_W-1:0]  command;
    logic [ADDR_W-1:0] address;
    logic              processing;

    modport master (
        output in_valid, in_cmd, in_addr, processing,
        input  in_ready, write, command, address
    );

    modport slave (
        input  in_valid, in_cmd, in_addr, processing,
        output in_ready, write, command, address
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding {cmd, addr} entries; DEPTH must be a power of two so pointers wrap naturally.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = cache_pkg::ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count alone say which slots hold valid data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: non-blocking assignments so every register here samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cache_cmd_dispatcher.sv
// Queues trace commands and issues them one at a time to the cache with a write/processing handshake.
// Optional per-command issue counters are built when DISPATCH_STATS_EN is defined.
module cache_cmd_dispatcher
    import cache_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_cmd_dispatcher_if.slave bus,
    output logic                  busy,
    output logic                  drained,
    output logic                  err_illegal,
    output logic                  err_timeout
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]           issued_cnt,
    output logic [31:0]           cmd_cnt_rd,
    output logic [31:0]           cmd_cnt_wr,
    output logic [31:0]           cmd_cnt_inv,
    output logic [31:0]           cmd_cnt_clr,
    output logic [31:0]           cmd_cnt_req
`endif
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    disp_state_e       state_q;
    disp_state_e       state_d;
    logic [TMR_W-1:0]  ack_tmr;
    logic [CMD_W-1:0]  cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              ack_timeout;
    entry_t            fifo_wdata;
    entry_t            fifo_rdata;

    // Illegal commands still complete the handshake so the trace never stalls on them.
    assign accept     = bus.in_valid && bus.in_ready;
    assign fifo_push  = accept && is_legal_cmd(bus.in_cmd);
    assign fifo_wdata = {bus.in_cmd, bus.in_addr};

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        fifo_pop    = 1'b0;
        ack_timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !bus.processing) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE:    state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.processing) begin
                    state_d = WAIT_DONE;
                end else if (ack_tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
                    ack_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.processing) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ack_tmr     <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            // The timer only runs while waiting for the cache to pick the command up.
            if (state_q == WAIT_ACK && !bus.processing && !ack_timeout) ack_tmr <= ack_tmr + 1'b1;
            else                                                          ack_tmr <= '0;
            if (fifo_pop) begin
                cmd_q  <= fifo_rdata.cmd;
                addr_q <= fifo_rdata.addr;
            end
            if (accept && !is_legal_cmd(bus.in_cmd)) err_illegal <= 1'b1;
            if (ack_timeout)                         err_timeout <= 1'b1;
        end
    end

    assign bus.in_ready = !fifo_full;
    assign bus.write    = (state_q == ISSUE);
    assign bus.command  = cmd_q;
    assign bus.address  = addr_q;
    assign busy         = (state_q != IDLE);
    assign drained      = fifo_empty && (state_q == IDLE);

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt  <= '0;
            cmd_cnt_rd  <= '0;
            cmd_cnt_wr  <= '0;
            cmd_cnt_inv <= '0;
            cmd_cnt_clr <= '0;
            cmd_cnt_req <= '0;
        end else if (state_q == ISSUE) begin
            issued_cnt <= sat_inc(issued_cnt);
            case (cmd_q)
                CMD_READ:          cmd_cnt_rd  <= sat_inc(cmd_cnt_rd);
                CMD_WRITE:         cmd_cnt_wr  <= sat_inc(cmd_cnt_wr);
                CMD_INVALIDATE:    cmd_cnt_inv <= sat_inc(cmd_cnt_inv);
                CMD_CLEAR:         cmd_cnt_clr <= sat_inc(cmd_cnt_clr);
                CMD_L2DATAREQUEST: cmd_cnt_req <= sat_inc(cmd_cnt_req);
                default:           ;
            endcase
        end
    end
`endif

endmodule
